prog_loader: RTL

Program loader that fills the FRANK6000 instruction memory from a byte stream and holds the CPU in reset until the load completes. It accepts bytes over a valid/ready handshake and packs byte pairs, high byte first, into 16-bit instructions. Each instruction is written with a one-cycle write strobe at an incrementing address, and the whole image is checked against a trailing 8-bit checksum. At the top level, `o_addr`, `o_instr` and `o_we` are muxed onto the instruction memory address, data and write-enable while `o_busy` is high, and `o_cpu_rst` drives the CPU reset.

---
 rtl/prog_loader_pkg.sv | 24 ++
 rtl/prog_loader.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared definitions for the FRANK6000 program loader.
//   state_t   - loader state encodings (IDLE, HI, LO, WRITE, CSUM, DONE, ERR)
//   csum_add  - modulo-256 running checksum step
package prog_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HI    = 3'd1,
      ST_LO    = 3'd2,
      ST_WRITE = 3'd3,
      ST_CSUM  = 3'd4,
      ST_DONE  = 3'd5,
      ST_ERR   = 3'd6
   } state_t;

   localparam int BYTE_W = 8;

   // Running checksum: plain 8-bit add, wraps modulo 256.
   function automatic logic [BYTE_W-1:0] csum_add(input logic [BYTE_W-1:0] sum,
                                                  input logic [BYTE_W-1:0] data);
      return sum + data;
   endfunction

endpackage

// File: rtl/prog_loader.sv
// prog_loader: fills the instruction memory from a byte stream and holds the
// CPU in reset until the image has been loaded and its checksum verified.
// Ports:
//   i_clk, i_rst (async, active-low)
//   i_start, i_count   - begin a load of i_count+1 words (sampled in IDLE/DONE/ERR)
//   i_valid, i_byte    - stream byte, transferred when i_valid && o_ready
//   o_ready            - byte accepted this cycle (HI, LO, CSUM)
//   o_addr, o_instr,
//   o_we               - one-cycle instruction memory write
//   o_cpu_rst          - active-high CPU reset, low only after a good load
//   o_busy, o_done, o_err - load status
// All outputs are registers loaded from the next-state decode, so nothing
// depends combinationally on i_valid.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int addr_width = 8,
   parameter int data_width = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [addr_width-1:0] i_count,
   input  logic                  i_valid,
   input  logic [7:0]            i_byte,
   output logic                  o_ready,
   output logic [addr_width-1:0] o_addr,
   output logic [data_width-1:0] o_instr,
   output logic                  o_we,
   output logic                  o_cpu_rst,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_err
);

   state_t                  state_r;
   state_t                  state_nxt_s;
   logic [addr_width-1:0]   count_r;
   logic [addr_width-1:0]   cnt_r;
   logic [7:0]              sum_r;
   logic [addr_width-1:0]   addr_r;
   logic [data_width-1:0]   instr_r;
   logic                    ready_r;
   logic                    we_r;
   logic                    cpu_rst_r;
   logic                    busy_r;
   logic                    done_r;
   logic                    err_r;

   logic                    xfer_s;
   logic                    last_s;
   logic                    start_s;

   // ready_r mirrors "current state is HI, LO or CSUM"
   assign xfer_s  = i_valid & ready_r;
   // Compare before increment, so count 0xFF ends at address 0xFF without wrap
   assign last_s  = (cnt_r == count_r);
   assign start_s = i_start & ((state_r == ST_IDLE) | (state_r == ST_DONE) | (state_r == ST_ERR));

   // Next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (i_start) state_nxt_s = ST_HI;
            else         state_nxt_s = state_r;
         end
         ST_HI: begin
            if (xfer_s) state_nxt_s = ST_LO;
            else        state_nxt_s = ST_HI;
         end
         ST_LO: begin
            if (xfer_s) state_nxt_s = ST_WRITE;
            else        state_nxt_s = ST_LO;
         end
         ST_WRITE: begin
            if (last_s) state_nxt_s = ST_CSUM;
            else        state_nxt_s = ST_HI;
         end
         ST_CSUM: begin
            if (xfer_s) state_nxt_s = (i_byte == sum_r) ? ST_DONE : ST_ERR;
            else        state_nxt_s = ST_CSUM;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State register and registered status outputs decoded from the next state
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_r   <= ST_IDLE;
         ready_r   <= 1'b0;
         we_r      <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         err_r     <= 1'b0;
         cpu_rst_r <= 1'b1;
      end else begin
         state_r   <= state_nxt_s;
         ready_r   <= (state_nxt_s == ST_HI) | (state_nxt_s == ST_LO) | (state_nxt_s == ST_CSUM);
         we_r      <= (state_nxt_s == ST_WRITE);
         busy_r    <= (state_nxt_s == ST_HI) | (state_nxt_s == ST_LO) |
                      (state_nxt_s == ST_WRITE) | (state_nxt_s == ST_CSUM);
         done_r    <= (state_nxt_s == ST_DONE);
         err_r     <= (state_nxt_s == ST_ERR);
         cpu_rst_r <= (state_nxt_s != ST_DONE);
      end
   end

   // Datapath: count latch, word counter, byte assembly, checksum, write address
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         count_r <= {addr_width{1'b0}};
         cnt_r   <= {addr_width{1'b0}};
         sum_r   <= 8'h00;
         addr_r  <= {addr_width{1'b0}};
         instr_r <= {data_width{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (start_s) begin
                  count_r <= i_count;
                  cnt_r   <= {addr_width{1'b0}};
                  sum_r   <= 8'h00;
               end else begin
                  count_r <= count_r;
               end
            end
            ST_HI: begin
               if (xfer_s) begin
                  instr_r[15:8] <= i_byte;
                  sum_r         <= csum_add(sum_r, i_byte);
               end else begin
                  sum_r <= sum_r;
               end
            end
            ST_LO: begin
               if (xfer_s) begin
                  instr_r[7:0] <= i_byte;
                  sum_r        <= csum_add(sum_r, i_byte);
                  // Address is set up on entry to WRITE and then held
                  addr_r       <= cnt_r;
               end else begin
                  sum_r <= sum_r;
               end
            end
            ST_WRITE: begin
               if (!last_s) cnt_r <= cnt_r + addr_width'(1);
               else         cnt_r <= cnt_r;
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

   assign o_ready   = ready_r;
   assign o_addr    = addr_r;
   assign o_instr   = instr_r;
   assign o_we      = we_r;
   assign o_cpu_rst = cpu_rst_r;
   assign o_busy    = busy_r;
   assign o_done    = done_r;
   assign o_err     = err_r;

endmodule
